button_conditioner: RTL and testbench

Parametrised N-channel input conditioner replacing the fixed two- and eight-input debouncers that feed the image pipeline from the board buttons and the NES pad. Each channel is synchronised, debounced, and edge-detected. Each channel also has a per-channel auto-repeat mode, so a held direction or button produces a delayed train of pulses. It sits between the raw pad/button pins and the `ImageOutput` control inputs, in the pixel clock domain.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 121 ++++++++++++
 rtl/button_conditioner.sv | 40 ++++
 tb/tb_button_conditioner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: synchroniser, debounce counter, edge pulses and auto-repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 252000,
    parameter int unsigned REPEAT_DELAY    = 12600000,
    parameter int unsigned REPEAT_PERIOD   = 2520000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic pulse
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [DW-1:0]          dcnt;
    logic                   toggle_c;
    logic                   rise_c;
    logic                   fall_c;
    rpt_state_t             state, state_nxt;
    logic [RW-1:0]          rcnt, rcnt_nxt;
    logic                   rpt_evt_c;

    assign s        = sync[SYNC_STAGES-1];
    assign toggle_c = (s != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise_c   = toggle_c & ~level;
    assign fall_c   = toggle_c & level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Any disagreement that does not last the full window discards progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt          <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise_c;
            release_pulse <= fall_c;
            if ((s == level) || toggle_c) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            if (toggle_c) begin
                level <= ~level;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            pulse <= rise_c | rpt_evt_c;
        end
    end

    // Entry is taken on the same edge that registers press; exit beats a due repeat.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rpt_evt_c = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c && repeat_en) begin
                    state_nxt = DELAY;
                    rcnt_nxt  = '0;
                end
            end
            DELAY: begin
                if (fall_c || !repeat_en) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                    rpt_evt_c = 1'b1;
                    state_nxt = REPEAT;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            REPEAT: begin
                if (fall_c || !repeat_en) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                    rpt_evt_c = 1'b1;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// N independent button/pad channels feeding the image pipeline controls.
// The falling-edge output is release_pulse because "release" is a reserved word.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS        = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 252000,
    parameter int unsigned REPEAT_DELAY    = 12600000,
    parameter int unsigned REPEAT_PERIOD   = 2520000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_in       (btn_in[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .pulse        (pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected output events are queued by cycle when stimulus is driven.
module tb_button_conditioner;

    localparam int unsigned CH  = 2;
    localparam int unsigned SS  = 2;
    localparam int unsigned DC  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int unsigned LAT = SS + DC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] repeat_en;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] pulse;

    typedef struct {
        int unsigned cyc;
        int unsigned ch;
        logic        p;
        logic        r;
        logic        u;
    } ev_t;

    ev_t           sb[$];
    logic [CH-1:0] exp_level = '0;
    logic [CH-1:0] ep, er, eu;
    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int unsigned   t;

    button_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .pulse        (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int unsigned c, input int unsigned ch,
                        input logic p, input logic r, input logic u);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        e.p   = p;
        e.r   = r;
        e.u   = u;
        sb.push_back(e);
    endtask

    // Sample 1 time unit after each edge; cyc counts edges since time 0.
    always @(posedge clk) begin
        cyc++;
        #1;
        ep = '0;
        er = '0;
        eu = '0;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].p) begin
                    ep[sb[i].ch] = 1'b1;
                    exp_level[sb[i].ch] = 1'b1;
                end
                if (sb[i].r) begin
                    er[sb[i].ch] = 1'b1;
                    exp_level[sb[i].ch] = 1'b0;
                end
                if (sb[i].u) eu[sb[i].ch] = 1'b1;
                sb.delete(i);
            end
        end
        check("press", 32'(press), 32'(ep));
        check("release", 32'(release_pulse), 32'(er));
        check("pulse", 32'(pulse), 32'(eu));
        check("level", 32'(level), 32'(exp_level));
    end

    initial begin
        rst_n     = 1'b0;
        btn_in    = '0;
        repeat_en = '0;
        repeat (3) @(negedge clk);
        check("reset_level", 32'(level), 0);
        check("reset_pulse", 32'(pulse), 0);
        rst_n = 1'b1;

        // Clean press and release, no repeat
        @(negedge clk);
        btn_in[0] = 1'b1;
        push(cyc + LAT, 0, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        btn_in[0] = 1'b0;
        push(cyc + LAT, 0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Glitch one cycle short of the debounce window
        btn_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Bounce on channel 1, final toggle leaves it high
        for (int i = 0; i < 11; i++) begin
            btn_in[1] = ~btn_in[1];
            if (i < 10) @(negedge clk);
        end
        push(cyc + LAT, 1, 1'b1, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        btn_in[1] = 1'b0;
        push(cyc + LAT, 1, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Auto-repeat; the repeat due at the release edge is suppressed
        repeat_en[0] = 1'b1;
        t = cyc;
        btn_in[0] = 1'b1;
        push(t + LAT, 0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) push(t + LAT + RD + k * RP, 0, 1'b0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        btn_in[0] = 1'b0;
        push(cyc + LAT, 0, 1'b0, 1'b1, 1'b0);
        repeat (15) @(negedge clk);

        // Drop repeat_en just before a due repeat, then re-enable while held
        t = cyc;
        btn_in[0] = 1'b1;
        push(t + LAT, 0, 1'b1, 1'b0, 1'b1);
        push(t + LAT + RD, 0, 1'b0, 1'b0, 1'b1);
        push(t + LAT + RD + RP, 0, 1'b0, 1'b0, 1'b1);
        repeat (21) @(negedge clk);
        repeat_en[0] = 1'b0;
        repeat (5) @(negedge clk);
        repeat_en[0] = 1'b1;
        repeat (20) @(negedge clk);
        btn_in[0] = 1'b0;
        push(cyc + LAT, 0, 1'b0, 1'b1, 1'b0);
        repeat (12) @(negedge clk);

        // Reset while a repeat pulse is high, input still held afterwards
        t = cyc;
        btn_in[0] = 1'b1;
        push(t + LAT, 0, 1'b1, 1'b0, 1'b1);
        push(t + LAT + RD, 0, 1'b0, 1'b0, 1'b1);
        push(t + LAT + RD + RP, 0, 1'b0, 1'b0, 1'b1);
        push(t + LAT + RD + 2 * RP, 0, 1'b0, 1'b0, 1'b1);
        repeat (21) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        exp_level = '0;
        repeat_en = '0;
        #1;
        check("async_rst_level", 32'(level), 0);
        check("async_rst_press", 32'(press), 0);
        check("async_rst_release", 32'(release_pulse), 0);
        check("async_rst_pulse", 32'(pulse), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(cyc + LAT, 0, 1'b1, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        btn_in[0] = 1'b0;
        push(cyc + LAT, 0, 1'b0, 1'b1, 1'b0);
        repeat (12) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
